mem_port_arbiter: RTL and testbench

- Shares the single unified memory port between two requesters: the instruction-fetch path (IF stage) and the data path (LW/LBu/LBs/SW/SV in the MEM stage).
- Sequences each access over a fixed multi-cycle memory latency and returns an acknowledge with read data.
- Performs byte-lane selection and zero/sign extension for LBu/LBs, and generates byte enables for writes.
- Sits between the control unit/datapath and the memory macro.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_port_arbiter_byte_lane.sv | 34 +++
 rtl/mem_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the unified memory-port arbiter.
package mem_arb_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } state_e;

    typedef enum logic {
        GNT_IF,
        GNT_D
    } grant_e;

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_byte_lane.sv
// Byte-lane steering: load extract/extend and store replicate/byte-enable.
module byte_lane_unit
    import mem_arb_pkg::*;
(
    input  logic              is_byte,
    input  logic              sext,
    input  logic              lane,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata_in,
    input  logic [DATA_W-1:0] rdata_in,
    output logic [1:0]        be,
    output logic [DATA_W-1:0] wdata_out,
    output logic [DATA_W-1:0] rdata_out
);

    logic [7:0] byte_v;

    // Select the addressed byte for loads and shape enables/data for stores.
    always_comb begin
        // NOTE: every output gets a default before any branch so no latch is inferred.
        byte_v    = lane ? rdata_in[15:8] : rdata_in[7:0];
        be        = BE_W;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        if (is_byte) begin
            rdata_out = {{8{sext & byte_v[7]}}, byte_v};
            if (we) begin
                be        = lane ? BE_HI : BE_LO;
                wdata_out = {2{wdata_in[7:0]}};
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and data paths.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic              d_sext,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_e            state_q, state_d;
    grant_e            gnt_q, last_q;
    logic [3:0]        cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, byte_q, sext_q, err_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

    logic              take_if, take_d, misalign;
    logic              busy, resp;
    logic [1:0]        lane_be;
    logic [DATA_W-1:0] lane_wdata, lane_rdata;

    byte_lane_unit u_lane (
        .is_byte   (byte_q),
        .sext      (sext_q),
        .lane      (addr_q[0]),
        .we        (we_q),
        .wdata_in  (wdata_q),
        .rdata_in  (mem_rdata),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata)
    );

    // Next-state and grant decision; round-robin only matters on a tie.
    always_comb begin
        state_d  = state_q;
        take_if  = 1'b0;
        take_d   = 1'b0;
        misalign = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req && d_req) begin
                    if (last_q == GNT_D) take_if = 1'b1;
                    else                 take_d  = 1'b1;
                end else if (if_req) begin
                    take_if = 1'b1;
                end else if (d_req) begin
                    take_d = 1'b1;
                end
                // A misaligned word access skips the memory cycle entirely.
                misalign = take_d && !d_byte && d_addr[0];
                if (misalign)              state_d = ST_RESP;
                else if (take_if || take_d) state_d = ST_BUSY;
            end
            ST_BUSY: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, latched request, latency counter and response registers.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers updating from pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_IF;
            last_q     <= GNT_D;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            sext_q     <= 1'b0;
            err_q      <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take_if) begin
                gnt_q   <= GNT_IF;
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                byte_q  <= 1'b0;
                sext_q  <= 1'b0;
                wdata_q <= '0;
                err_q   <= 1'b0;
                cnt_q   <= CNT_INIT;
            end else if (take_d) begin
                gnt_q   <= GNT_D;
                addr_q  <= d_addr;
                we_q    <= d_we;
                byte_q  <= d_byte;
                sext_q  <= d_sext;
                wdata_q <= d_wdata;
                err_q   <= misalign;
                cnt_q   <= CNT_INIT;
                if (misalign) d_rdata_q <= '0;
            end
            if (state_q == ST_BUSY) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else if (gnt_q == GNT_IF) begin
                    if_rdata_q <= lane_rdata;
                end else begin
                    d_rdata_q <= lane_rdata;
                end
            end
            if (state_q == ST_RESP) last_q <= gnt_q;
        end
    end

    assign busy = (state_q == ST_BUSY);
    assign resp = (state_q == ST_RESP);

    assign if_ack    = resp && (gnt_q == GNT_IF);
    assign d_ack     = resp && (gnt_q == GNT_D);
    assign d_err     = d_ack && err_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    // Memory-side signals are only driven during the access window.
    assign mem_en    = busy;
    assign mem_we    = busy && we_q;
    assign mem_be    = busy ? lane_be : 2'b00;
    assign mem_addr  = busy ? {addr_q[ADDR_W-1:1], 1'b0} : '0;
    assign mem_wdata = (busy && we_q) ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: drivers queue expected acks and memory cycles, monitors compare.
module tb_mem_port_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0;
    logic        d_we = 1'b0, d_byte = 1'b0, d_sext = 1'b0;
    logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        if_ack, d_ack, d_err, mem_en, mem_we;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic [1:0]  mem_be;

    typedef struct {
        logic        is_d;
        logic [15:0] rdata;
        logic        err;
        logic        chk_rdata;
        int          ack_cyc;
    } ack_item_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] wdata;
    } mem_item_t;

    ack_item_t exp_q[$];
    mem_item_t mem_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_sext(d_sext),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ack(input logic is_d, input logic [15:0] rd, input logic err,
                            input logic chk, input int at);
        ack_item_t it;
        it.is_d = is_d; it.rdata = rd; it.err = err; it.chk_rdata = chk; it.ack_cyc = at;
        exp_q.push_back(it);
    endtask

    task automatic push_mem(input logic [15:0] a, input logic we, input logic [1:0] be,
                            input logic [15:0] wd);
        mem_item_t m;
        m.addr = a; m.we = we; m.be = be; m.wdata = wd;
        mem_q.push_back(m);
    endtask

    // Bounded wait for n acks, then release both requests.
    task automatic wait_acks(input int n);
        int seen = 0;
        for (int i = 0; i < 60 && seen < n; i++) begin
            @(negedge clk);
            if (if_ack || d_ack) seen++;
        end
        check("acks_seen", seen, n);
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] a, input logic [15:0] mrd, input logic [15:0] maddr);
        @(negedge clk);
        mem_rdata = mrd;
        push_mem(maddr, 1'b0, 2'b11, 16'h0000);
        push_ack(1'b0, mrd, 1'b0, 1'b1, cyc + MEM_LAT + 1);
        if_addr = a;
        if_req  = 1'b1;
        wait_acks(1);
    endtask

    task automatic do_data(input logic we, input logic bt, input logic sx, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] mrd, input logic [15:0] exp_rd,
                           input logic [15:0] maddr, input logic [1:0] be, input logic [15:0] mwd);
        @(negedge clk);
        mem_rdata = mrd;
        push_mem(maddr, we, be, mwd);
        push_ack(1'b1, exp_rd, 1'b0, !we, cyc + MEM_LAT + 1);
        d_we = we; d_byte = bt; d_sext = sx; d_addr = a; d_wdata = wd;
        d_req = 1'b1;
        wait_acks(1);
    endtask

    // Ack scoreboard monitor.
    initial forever begin
        ack_item_t it;
        @(negedge clk);
        if (if_ack || d_ack) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {if_ack, d_ack}, 2'b00);
            end else begin
                it = exp_q.pop_front();
                check("ack_kind", {if_ack, d_ack}, it.is_d ? 2'b01 : 2'b10);
                check("ack_cycle", cyc, it.ack_cyc);
                if (it.is_d) begin
                    check("d_err", d_err, it.err);
                    if (it.chk_rdata) check("d_rdata", d_rdata, it.rdata);
                end else begin
                    check("if_rdata", if_rdata, it.rdata);
                end
            end
        end
    end

    // Memory-port monitor: contents stable for the whole window, window length MEM_LAT.
    initial begin
        bit        active = 0;
        bit        have   = 0;
        int        len    = 0;
        mem_item_t cur;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (!active) begin
                    active = 1;
                    len    = 0;
                    have   = (mem_q.size() != 0);
                    if (have) cur = mem_q.pop_front();
                    else      check("unexpected_mem_en", mem_en, 1'b0);
                end
                len++;
                if (have) begin
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_we", mem_we, cur.we);
                    check("mem_be", mem_be, cur.be);
                    if (cur.we) check("mem_wdata", mem_wdata, cur.wdata);
                end
            end else if (active) begin
                active = 0;
                check("mem_en_len", len, MEM_LAT);
            end
        end
    end

    initial begin
        int c;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_if_ack", if_ack, 1'b0);
        check("rst_d_ack", d_ack, 1'b0);
        check("rst_d_err", d_err, 1'b0);
        check("rst_if_rdata", if_rdata, 16'h0000);
        check("rst_d_rdata", d_rdata, 16'h0000);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_be", mem_be, 2'b00);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        rst = 1'b0;

        do_fetch(16'h0010, 16'h3A5C, 16'h0010);
        //      we bt sx addr      wdata     mem_rdata exp_rd    maddr     be     mem_wdata
        do_data(0, 1, 1, 16'h0021, 16'h0000, 16'h9C12, 16'hFF9C, 16'h0020, 2'b11, 16'h0000);
        do_data(0, 1, 0, 16'h0021, 16'h0000, 16'h9C12, 16'h009C, 16'h0020, 2'b11, 16'h0000);
        do_data(0, 1, 1, 16'h0020, 16'h0000, 16'h9C12, 16'h0012, 16'h0020, 2'b11, 16'h0000);
        do_data(1, 1, 0, 16'h0030, 16'h00AB, 16'h0000, 16'h0000, 16'h0030, 2'b01, 16'hABAB);
        do_data(1, 1, 0, 16'h0031, 16'h00CD, 16'h0000, 16'h0000, 16'h0030, 2'b10, 16'hCDCD);
        do_data(1, 0, 0, 16'h0032, 16'h1234, 16'h0000, 16'h0000, 16'h0032, 2'b11, 16'h1234);

        // Misaligned word load: error ack one cycle after accept, no memory cycle.
        @(negedge clk);
        mem_rdata = 16'hFFFF;
        push_ack(1'b1, 16'h0000, 1'b1, 1'b1, cyc + 1);
        d_we = 1'b0; d_byte = 1'b0; d_sext = 1'b0; d_addr = 16'h0041;
        d_req = 1'b1;
        wait_acks(1);

        do_fetch(16'h0015, 16'h4321, 16'h0014);
        do_data(0, 0, 0, 16'h0022, 16'h0000, 16'hBEEF, 16'hBEEF, 16'h0022, 2'b11, 16'h0000);

        // Both requesters held: last grant was data, so F, D, F, D at 4-cycle spacing.
        @(negedge clk);
        c = cyc;
        mem_rdata = 16'h7E01;
        for (int i = 0; i < 4; i++) begin
            push_ack(i[0], 16'h7E01, 1'b0, 1'b1, c + 3 + 4 * i);
            push_mem(i[0] ? 16'h0050 : 16'h0060, 1'b0, 2'b11, 16'h0000);
        end
        if_addr = 16'h0060;
        d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0050;
        if_req = 1'b1; d_req = 1'b1;
        wait_acks(4);

        // Leave last grant on fetch, then abort a store with reset in its 2nd busy cycle.
        do_fetch(16'h00A0, 16'h1111, 16'h00A0);
        @(negedge clk);
        push_mem(16'h0070, 1'b1, 2'b01, 16'h5A5A);
        d_we = 1'b1; d_byte = 1'b1; d_sext = 1'b0; d_addr = 16'h0070; d_wdata = 16'h005A;
        d_req = 1'b1;
        @(negedge clk);
        check("abort_busy1_en", mem_en, 1'b1);
        @(negedge clk);
        check("abort_busy2_we", mem_we, 1'b1);
        rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("abort_mem_en", mem_en, 1'b0);
        check("abort_mem_we", mem_we, 1'b0);
        check("abort_d_ack", d_ack, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Tie after reset: fetch must win.
        c = cyc;
        mem_rdata = 16'h5555;
        push_ack(1'b0, 16'h5555, 1'b0, 1'b1, c + 3);
        push_ack(1'b1, 16'h5555, 1'b0, 1'b1, c + 7);
        push_mem(16'h0090, 1'b0, 2'b11, 16'h0000);
        push_mem(16'h0080, 1'b0, 2'b11, 16'h0000);
        if_addr = 16'h0090;
        d_we = 1'b0; d_byte = 1'b0; d_addr = 16'h0080;
        if_req = 1'b1; d_req = 1'b1;
        wait_acks(2);

        repeat (3) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("mem_q_empty", mem_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
